// File: rtl/itf_pkg.sv
// Shared types and constants for the chip-side pad-bus interface controller.
package itf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISA,
    ST_CMD,
    ST_IN2CHIP,
    ST_OUT2OFF,
    ST_DONE
  } itf_state_e;

  // Bit positions of the command word fields driven onto the bus in CMD.
  localparam int DIR_BIT  = 0;
  localparam int ADDR_LSB = 1;
  localparam int NUM_LSB  = 33;

  localparam int OPCODE_WIDTH = 4;

endpackage

// File: rtl/itf_xfer_cnt.sv
// Transfer word counter: cleared when a request is latched, flags the handshake
// that completes the transfer.
module itf_xfer_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] num_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last_o = inc_i && ((cnt_q + 1'b1) == num_i);

endmodule

// File: rtl/itf_core_ctrl.sv
// Pad-bus interface controller: routes host ISA words to config consumers and
// runs GLB<->DRAM transfers (command, data stream, done) over the shared bus.
module itf_core_ctrl #(
  parameter int PORT_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 16,
  parameter int DRAM_ADDR_WIDTH = 32,
  parameter int OPNUM           = 6,
  parameter int OPCODE_WIDTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       I_ISAVld,
  input  logic [PORT_WIDTH-1:0]      I_Dat,
  input  logic                       I_DatVld,
  output logic                       O_DatRdy,
  output logic [PORT_WIDTH-1:0]      O_Dat,
  output logic                       O_DatVld,
  input  logic                       I_DatRdy,
  output logic                       O_DatOE,
  output logic                       O_CmdVld,
  output logic [OPNUM-1:0]           O_CfgRdy,
  input  logic [OPNUM-1:0]           I_ModCfgRdy,
  output logic [PORT_WIDTH-1:0]      O_ModISADat,
  output logic [OPNUM-1:0]           O_ModISAVld,
  input  logic [OPNUM-1:0]           I_ModISARdy,
  input  logic                       I_ReqVld,
  output logic                       O_ReqRdy,
  input  logic                       I_ReqDir,
  input  logic [DRAM_ADDR_WIDTH-1:0] I_ReqAddr,
  input  logic [ADDR_WIDTH-1:0]      I_ReqNum,
  output logic [PORT_WIDTH-1:0]      O_WrDat,
  output logic                       O_WrDatVld,
  input  logic                       I_WrDatRdy,
  input  logic [PORT_WIDTH-1:0]      I_RdDat,
  input  logic                       I_RdDatVld,
  output logic                       O_RdDatRdy,
  output logic                       O_ReqDone,
  output logic                       O_ProtErr
);
  import itf_pkg::*;

  itf_state_e                 state_q, state_d;
  logic                       dir_q;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0]      num_q;
  logic                       isa_vld_q, prot_err_q;
  logic [OPNUM-1:0]           cfg_rdy_q, cfg_rdy_d;
  logic [OPNUM-1:0]           isa_hit;
  logic                       isa_rdy, op_ok, busy, req_acc, cnt_inc, cnt_last, prot_d;
  logic [PORT_WIDTH-1:0]      cmd_word;

  // Opcode decode; unknown opcodes are swallowed (ready high, no valid).
  always_comb begin
    isa_hit = '0;
    isa_rdy = 1'b1;
    for (int i = 0; i < OPNUM; i++) begin
      if (I_Dat[OPCODE_WIDTH-1:0] == OPCODE_WIDTH'(i)) begin
        isa_hit[i] = 1'b1;
        isa_rdy    = I_ModISARdy[i];
      end
    end
  end
  assign op_ok = |isa_hit;

  always_comb begin
    cmd_word = '0;
    cmd_word[DIR_BIT]                     = dir_q;
    cmd_word[ADDR_LSB +: DRAM_ADDR_WIDTH] = addr_q;
    cmd_word[NUM_LSB +: ADDR_WIDTH]       = num_q;
  end

  assign busy    = (state_q == ST_CMD) || (state_q == ST_IN2CHIP) || (state_q == ST_OUT2OFF);
  assign req_acc = (state_q == ST_IDLE) && !I_ISAVld && I_ReqVld;
  assign cnt_inc = ((state_q == ST_IN2CHIP) && I_DatVld && I_WrDatRdy) ||
                   ((state_q == ST_OUT2OFF) && I_RdDatVld && I_DatRdy);
  assign prot_d  = ((state_q == ST_ISA) && I_DatVld && !op_ok) ||
                   (busy && I_ISAVld && !isa_vld_q);

  itf_xfer_cnt #(.W(ADDR_WIDTH)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (req_acc),
    .inc_i  (cnt_inc),
    .num_i  (num_q),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (I_ISAVld) state_d = ST_ISA;
                  else if (I_ReqVld) state_d = ST_CMD;
      ST_ISA:     if (!I_ISAVld) state_d = ST_IDLE;
      ST_CMD:     if (I_DatRdy) state_d = (num_q == '0) ? ST_DONE :
                                          (dir_q ? ST_OUT2OFF : ST_IN2CHIP);
      ST_IN2CHIP,
      ST_OUT2OFF: if (cnt_last) state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Config-ready is registered against the next state so it lines up with state_q.
  always_comb begin
    cfg_rdy_d = I_ModCfgRdy;
    if (state_d inside {ST_CMD, ST_IN2CHIP, ST_OUT2OFF}) cfg_rdy_d = '0;
    else if (state_d == ST_DONE) cfg_rdy_d[OPNUM-1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      addr_q     <= '0;
      num_q      <= '0;
      isa_vld_q  <= 1'b0;
      prot_err_q <= 1'b0;
      cfg_rdy_q  <= '0;
    end else begin
      state_q   <= state_d;
      isa_vld_q <= I_ISAVld;
      cfg_rdy_q <= cfg_rdy_d;
      if (prot_d) prot_err_q <= 1'b1;
      if (req_acc) begin
        dir_q  <= I_ReqDir;
        addr_q <= I_ReqAddr;
        num_q  <= I_ReqNum;
      end
    end
  end

  assign O_CfgRdy  = cfg_rdy_q;
  assign O_ProtErr = prot_err_q;

  always_comb begin
    O_DatRdy    = 1'b0;
    O_Dat       = '0;
    O_DatVld    = 1'b0;
    O_DatOE     = 1'b0;
    O_CmdVld    = 1'b0;
    O_ModISADat = '0;
    O_ModISAVld = '0;
    O_ReqRdy    = 1'b0;
    O_WrDat     = '0;
    O_WrDatVld  = 1'b0;
    O_RdDatRdy  = 1'b0;
    O_ReqDone   = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: O_ReqRdy = req_acc;
        ST_ISA: begin
          O_ModISADat = I_Dat;
          O_ModISAVld = isa_hit & {OPNUM{I_DatVld}};
          O_DatRdy    = isa_rdy;
        end
        ST_CMD: begin
          O_DatOE  = 1'b1;
          O_CmdVld = 1'b1;
          O_DatVld = 1'b1;
          O_Dat    = cmd_word;
        end
        ST_IN2CHIP: begin
          O_WrDat    = I_Dat;
          O_WrDatVld = I_DatVld;
          O_DatRdy   = I_WrDatRdy;
        end
        ST_OUT2OFF: begin
          O_DatOE    = 1'b1;
          O_Dat      = I_RdDat;
          O_DatVld   = I_RdDatVld;
          O_RdDatRdy = I_DatRdy;
        end
        ST_DONE: O_ReqDone = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_itf_core_ctrl.sv
// Bench for itf_core_ctrl: ISA routing vector table, directed corner sequences and
// randomized transfers checked against a transaction-level expectation.
module tb_itf_core_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         I_ISAVld;
  logic [127:0] I_Dat;
  logic         I_DatVld;
  logic         O_DatRdy;
  logic [127:0] O_Dat;
  logic         O_DatVld;
  logic         I_DatRdy;
  logic         O_DatOE;
  logic         O_CmdVld;
  logic [5:0]   O_CfgRdy;
  logic [5:0]   I_ModCfgRdy;
  logic [127:0] O_ModISADat;
  logic [5:0]   O_ModISAVld;
  logic [5:0]   I_ModISARdy;
  logic         I_ReqVld;
  logic         O_ReqRdy;
  logic         I_ReqDir;
  logic [31:0]  I_ReqAddr;
  logic [15:0]  I_ReqNum;
  logic [127:0] O_WrDat;
  logic         O_WrDatVld;
  logic         I_WrDatRdy;
  logic [127:0] I_RdDat;
  logic         I_RdDatVld;
  logic         O_RdDatRdy;
  logic         O_ReqDone;
  logic         O_ProtErr;

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] cfg_base;

  itf_core_ctrl dut (
    .clk(clk), .rst_n(rst_n), .I_ISAVld(I_ISAVld), .I_Dat(I_Dat), .I_DatVld(I_DatVld),
    .O_DatRdy(O_DatRdy), .O_Dat(O_Dat), .O_DatVld(O_DatVld), .I_DatRdy(I_DatRdy),
    .O_DatOE(O_DatOE), .O_CmdVld(O_CmdVld), .O_CfgRdy(O_CfgRdy), .I_ModCfgRdy(I_ModCfgRdy),
    .O_ModISADat(O_ModISADat), .O_ModISAVld(O_ModISAVld), .I_ModISARdy(I_ModISARdy),
    .I_ReqVld(I_ReqVld), .O_ReqRdy(O_ReqRdy), .I_ReqDir(I_ReqDir), .I_ReqAddr(I_ReqAddr),
    .I_ReqNum(I_ReqNum), .O_WrDat(O_WrDat), .O_WrDatVld(O_WrDatVld), .I_WrDatRdy(I_WrDatRdy),
    .I_RdDat(I_RdDat), .I_RdDatVld(I_RdDatVld), .O_RdDatRdy(O_RdDatRdy),
    .O_ReqDone(O_ReqDone), .O_ProtErr(O_ProtErr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] op;
    logic       vld;
    logic [5:0] rdy;
    logic [5:0] exp_vld;
    logic       exp_rdy;
  } isa_vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // O_CfgRdy is expected to track I_ModCfgRdy as sampled at the previous edge.
  task automatic cyc();
    cfg_base = I_ModCfgRdy;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    I_ISAVld = 0; I_Dat = '0; I_DatVld = 0; I_DatRdy = 0; I_ModCfgRdy = '0;
    I_ModISARdy = '0; I_ReqVld = 0; I_ReqDir = 0; I_ReqAddr = '0; I_ReqNum = '0;
    I_WrDatRdy = 0; I_RdDat = '0; I_RdDatVld = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    cyc();
    cyc();
    rst_n = 1;
  endtask

  // One full request: IDLE accept, CMD word, num data beats, DONE pulse.
  // abort_at >= 0 resets the DUT once that many words have moved.
  task automatic xfer(input logic dir, input logic [31:0] addr, input logic [15:0] num,
                      input int abort_at, input int stall);
    logic [127:0] cmd;
    logic [127:0] words[16];
    int k, guard;
    logic v, r;
    cmd = (128'(num) << 33) | (128'(addr) << 1) | 128'(dir);
    for (int i = 0; i < 16; i++) words[i] = {$urandom, $urandom, $urandom, $urandom};
    I_ReqVld = 1; I_ReqDir = dir; I_ReqAddr = addr; I_ReqNum = num;
    I_ModCfgRdy = 6'($urandom);
    @(negedge clk);
    chk("req_rdy", O_ReqRdy, 1);
    chk("idle_cfg", O_CfgRdy, cfg_base);
    cyc();
    I_ReqVld = 0; I_ReqDir = ~dir; I_ReqAddr = $urandom; I_ReqNum = 16'($urandom);
    guard = $urandom_range(0, 2);
    for (int i = 0; i <= guard; i++) begin
      I_DatRdy = (i == guard);
      I_DatVld = 1'($urandom_range(0, 1));
      I_ModCfgRdy = 6'($urandom);
      @(negedge clk);
      chk("cmd_dat", O_Dat, cmd);
      chk("cmd_oe", O_DatOE, 1);
      chk("cmd_vld", {O_CmdVld, O_DatVld}, 2'b11);
      chk("cmd_cfg", O_CfgRdy, 0);
      chk("cmd_datrdy", O_DatRdy, 0);
      cyc();
    end
    I_DatRdy = 0; I_DatVld = 0;
    k = 0; guard = 0;
    while (k < int'(num) && guard < 300) begin
      if (k == abort_at) break;
      v = ($urandom_range(0, 99) >= stall);
      r = ($urandom_range(0, 99) >= stall);
      I_ModCfgRdy = 6'($urandom);
      if (!dir) begin I_Dat = words[k]; I_DatVld = v; I_WrDatRdy = r; end
      else begin I_RdDat = words[k]; I_RdDatVld = v; I_DatRdy = r; end
      @(negedge clk);
      chk("xf_cfg", O_CfgRdy, 0);
      chk("xf_done", O_ReqDone, 0);
      if (!dir) begin
        chk("in_oe", O_DatOE, 0);
        chk("in_vld", O_WrDatVld, v);
        chk("in_rdy", O_DatRdy, r);
        if (v) chk("in_dat", O_WrDat, words[k]);
      end else begin
        chk("out_oe", O_DatOE, 1);
        chk("out_vld", O_DatVld, v);
        chk("out_rdy", O_RdDatRdy, r);
        if (v) chk("out_dat", O_Dat, words[k]);
      end
      if (v && r) k++;
      cyc();
      guard++;
    end
    if (guard >= 300) chk("xf_budget", guard, 0);
    if (abort_at >= 0 && k == abort_at) begin
      clear_inputs();
      rst_n = 0;
      @(negedge clk);
      chk("rst_cyc_outs", {O_DatOE, O_DatVld, O_RdDatRdy, O_ReqDone}, 0);
      cyc();
      rst_n = 1;
      @(negedge clk);
      chk("rst_flags", {O_DatRdy, O_DatVld, O_DatOE, O_CmdVld, O_ReqRdy, O_WrDatVld,
                        O_RdDatRdy, O_ReqDone, O_ProtErr}, 0);
      chk("rst_cfg", O_CfgRdy, 0);
      chk("rst_dat", O_Dat | O_WrDat | O_ModISADat, 0);
      chk("rst_isavld", O_ModISAVld, 0);
      cyc();
      @(negedge clk);
      chk("rst_nodone", O_ReqDone, 0);
      chk("rst_cfg2", O_CfgRdy, cfg_base);
      cyc();
      return;
    end
    // Words still offered in DONE must not be accepted.
    I_DatVld = 1; I_RdDatVld = 1; I_DatRdy = 1; I_WrDatRdy = 1;
    I_ModCfgRdy = 6'($urandom);
    @(negedge clk);
    chk("done_pulse", O_ReqDone, 1);
    chk("done_cfg", O_CfgRdy, cfg_base | 6'h20);
    chk("done_rdy", {O_DatRdy, O_RdDatRdy, O_WrDatVld, O_DatOE}, 0);
    chk("done_perr", O_ProtErr, 0);
    cyc();
    clear_inputs();
    @(negedge clk);
    chk("post_done", O_ReqDone, 0);
    chk("post_cfg", O_CfgRdy, cfg_base);
    cyc();
  endtask

  initial begin
    isa_vec_t tv[11];
    int acc;
    tv[0]  = '{4'd2,  1'b1, 6'h3F, 6'b000100, 1'b1};
    tv[1]  = '{4'd2,  1'b1, 6'h3F, 6'b000100, 1'b1};
    tv[2]  = '{4'd5,  1'b1, 6'h3F, 6'b100000, 1'b1};
    tv[3]  = '{4'd3,  1'b1, 6'h37, 6'b001000, 1'b0};
    tv[4]  = '{4'd3,  1'b1, 6'h37, 6'b001000, 1'b0};
    tv[5]  = '{4'd3,  1'b1, 6'h37, 6'b001000, 1'b0};
    tv[6]  = '{4'd3,  1'b1, 6'h37, 6'b001000, 1'b0};
    tv[7]  = '{4'd3,  1'b1, 6'h3F, 6'b001000, 1'b1};
    tv[8]  = '{4'd0,  1'b0, 6'h3F, 6'b000000, 1'b1};
    tv[9]  = '{4'd9,  1'b1, 6'h00, 6'b000000, 1'b1};
    tv[10] = '{4'd15, 1'b0, 6'h00, 6'b000000, 1'b1};

    do_reset();
    @(negedge clk);
    chk("reset_oe", O_DatOE, 0);
    chk("reset_cfg", O_CfgRdy, 0);
    chk("reset_perr", O_ProtErr, 0);
    chk("reset_flags", {O_ReqDone, O_CmdVld, O_DatVld, O_DatRdy, O_ReqRdy}, 0);
    cyc();

    // ISA routing table
    I_ISAVld = 1;
    cyc();
    acc = 0;
    for (int i = 0; i < 11; i++) begin
      I_Dat = {$urandom, $urandom, $urandom, 28'($urandom), tv[i].op};
      I_DatVld = tv[i].vld;
      I_ModISARdy = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("isa_vld[%0d]", i), O_ModISAVld, tv[i].exp_vld);
      chk($sformatf("isa_rdy[%0d]", i), O_DatRdy, tv[i].exp_rdy);
      chk($sformatf("isa_dat[%0d]", i), O_ModISADat, I_Dat);
      if (i < 3 && I_DatVld && O_DatRdy) acc++;
      if (i == 8) chk("isa_perr_before", O_ProtErr, 0);
      cyc();
    end
    I_DatVld = 0;
    @(negedge clk);
    chk("isa_accepts", acc, 3);
    chk("isa_perr", O_ProtErr, 1);
    I_ISAVld = 0;
    cyc();
    cyc();

    // Directed transfers
    do_reset();
    xfer(1'b0, 32'h1000, 16'd4, -1, 0);
    xfer(1'b1, 32'hABCD_0123, 16'd3, -1, 50);

    // ISA wins over a request in the same IDLE cycle, then num = 0 transfer
    I_ISAVld = 1; I_ReqVld = 1; I_ReqNum = 16'd0; I_ModISARdy = '1;
    @(negedge clk);
    chk("prio_reqrdy", O_ReqRdy, 0);
    cyc();
    I_Dat = 128'd1; I_DatVld = 1;
    @(negedge clk);
    chk("prio_isavld", O_ModISAVld, 6'b000010);
    chk("prio_reqrdy_isa", {O_ReqRdy, O_CmdVld}, 0);
    cyc();
    I_ISAVld = 0; I_DatVld = 0;
    @(negedge clk);
    chk("prio_reqrdy_exit", O_ReqRdy, 0);
    cyc();
    xfer(1'b1, 32'h0000_0042, 16'd0, -1, 0);
    xfer(1'b0, 32'hFFFF_FFFF, 16'd0, -1, 0);

    // Reset in the middle of an outbound transfer
    xfer(1'b1, 32'h0000_5000, 16'd5, 2, 30);

    // ISA valid rising during a transfer flags an error but leaves the FSM alone
    do_reset();
    I_ReqVld = 1; I_ReqNum = 16'd2; I_ReqAddr = 32'h77;
    cyc();
    I_ReqVld = 0; I_ISAVld = 1;
    @(negedge clk);
    chk("poke_cmd", O_CmdVld, 1);
    chk("poke_perr0", O_ProtErr, 0);
    cyc();
    I_ISAVld = 0;
    @(negedge clk);
    chk("poke_perr", O_ProtErr, 1);
    chk("poke_still_cmd", O_CmdVld, 1);
    cyc();

    // Randomized transfers
    do_reset();
    for (int t = 0; t < 20; t++)
      xfer(1'($urandom_range(0, 1)), $urandom, 16'($urandom_range(0, 8)), -1,
           $urandom_range(0, 60));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
